// File: rtl/reload_replay_fifo.sv
// Single-clock FIFO with mark/rewind replay so a consumer can re-read a stored
// block for several passes; occupancy levels, thresholds and sticky error flags.
module reload_replay_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WIDTH  = 32,
  parameter bit          REPLAY = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wrdata,
  input  logic                       wren,
  input  logic                       rden,
  input  logic                       rd_mark,
  input  logic                       rd_rewind,
  input  logic [$clog2(DEPTH):0]     af_level,
  input  logic [$clog2(DEPTH):0]     ae_level,
  output logic [WIDTH-1:0]           rddata,
  output logic                       rddata_vld,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     rd_level,
  output logic [$clog2(DEPTH):0]     wr_level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wrptr_q, wrptr_d;
  logic [PW-1:0]    rdptr_q, rdptr_d;
  logic [PW-1:0]    mkptr_q, mkptr_d;
  logic [WIDTH-1:0] rddata_q, rddata_d;
  logic             rddata_vld_q, rddata_vld_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_acc;
  logic             rd_acc;
  logic             rewind_en;
  logic             mark_en;

  // Storage is bounded by the mark, not the read pointer, so marked data survives.
  assign rd_level     = wrptr_q - rdptr_q;
  assign wr_level     = wrptr_q - mkptr_q;
  assign full         = (wr_level == PW'(DEPTH));
  assign empty        = (rd_level == '0);
  assign almost_full  = (wr_level >= af_level);
  assign almost_empty = (rd_level <= ae_level);
  assign rddata       = rddata_q;
  assign rddata_vld   = rddata_vld_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  always_comb begin
    wr_acc       = wren && !full;
    rewind_en    = REPLAY && rd_rewind;
    mark_en      = REPLAY && rd_mark;
    rd_acc       = rden && !empty && !rewind_en;

    wrptr_d      = wrptr_q;
    rdptr_d      = rdptr_q;
    mkptr_d      = mkptr_q;
    rddata_d     = rddata_q;
    rddata_vld_d = rd_acc;
    overflow_d   = overflow_q | (wren && full);
    underflow_d  = underflow_q | (rden && empty && !rewind_en);

    if (wr_acc) wrptr_d = wrptr_q + PW'(1);

    if (rewind_en)   rdptr_d = mkptr_q;
    else if (rd_acc) rdptr_d = rdptr_q + PW'(1);

    if (rd_acc) rddata_d = mem_q[rdptr_q[AW-1:0]];

    // Mark captures the post-read pointer; a same-cycle rewind wins over it.
    if (!REPLAY)                     mkptr_d = rdptr_d;
    else if (mark_en && !rewind_en)  mkptr_d = rdptr_d;

    if (flush) begin
      wrptr_d      = '0;
      rdptr_d      = '0;
      mkptr_d      = '0;
      rddata_d     = '0;
      rddata_vld_d = 1'b0;
      overflow_d   = 1'b0;
      underflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrptr_q      <= '0;
      rdptr_q      <= '0;
      mkptr_q      <= '0;
      rddata_q     <= '0;
      rddata_vld_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wrptr_q      <= wrptr_d;
      rdptr_q      <= rdptr_d;
      mkptr_q      <= mkptr_d;
      rddata_q     <= rddata_d;
      rddata_vld_q <= rddata_vld_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem_q[wrptr_q[AW-1:0]] <= wrdata;
  end

endmodule

// File: tb/tb_reload_replay_fifo.sv
// Directed + random bench for reload_replay_fifo; checks a replay instance and a
// plain instance against queue-based reference models.
module tb_reload_replay_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic wren = 1'b0;
  logic rden = 1'b0;
  logic rd_mark = 1'b0;
  logic rd_rewind = 1'b0;
  logic [WIDTH-1:0] wrdata = '0;
  logic [3:0] af_level = 4'd6;
  logic [3:0] ae_level = 4'd1;

  logic [WIDTH-1:0] r_rddata, p_rddata;
  logic r_vld, r_full, r_afull, r_empty, r_aempty, r_ovf, r_unf;
  logic p_vld, p_full, p_afull, p_empty, p_aempty, p_ovf, p_unf;
  logic [3:0] r_rdl, r_wrl, p_rdl, p_wrl;

  int total = 0;
  int bad = 0;

  // replay model: entries from mark onward, read offset into them
  logic [WIDTH-1:0] rq[$];
  int roff = 0;
  logic [WIDTH-1:0] mr_dat = '0;
  bit mr_vld = 0, mr_ovf = 0, mr_unf = 0;
  // plain model: ordinary queue
  logic [WIDTH-1:0] pq[$];
  logic [WIDTH-1:0] mp_dat = '0;
  bit mp_vld = 0, mp_ovf = 0, mp_unf = 0;

  always #5 clk = ~clk;

  reload_replay_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REPLAY(1'b1)) u_rep (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wrdata(wrdata), .wren(wren),
    .rden(rden), .rd_mark(rd_mark), .rd_rewind(rd_rewind), .af_level(af_level),
    .ae_level(ae_level), .rddata(r_rddata), .rddata_vld(r_vld), .full(r_full),
    .almost_full(r_afull), .empty(r_empty), .almost_empty(r_aempty),
    .rd_level(r_rdl), .wr_level(r_wrl), .overflow(r_ovf), .underflow(r_unf)
  );

  reload_replay_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REPLAY(1'b0)) u_plain (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wrdata(wrdata), .wren(wren),
    .rden(rden), .rd_mark(rd_mark), .rd_rewind(rd_rewind), .af_level(af_level),
    .ae_level(ae_level), .rddata(p_rddata), .rddata_vld(p_vld), .full(p_full),
    .almost_full(p_afull), .empty(p_empty), .almost_empty(p_aempty),
    .rd_level(p_rdl), .wr_level(p_wrl), .overflow(p_ovf), .underflow(p_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete(); roff = 0; mr_dat = '0; mr_vld = 0; mr_ovf = 0; mr_unf = 0;
    pq.delete(); mp_dat = '0; mp_vld = 0; mp_ovf = 0; mp_unf = 0;
  endtask

  // Advance both models by one clock using the currently driven inputs.
  task automatic model_step();
    bit rfull, rempty, pfull, pempty;
    if (flush) begin
      model_reset();
      return;
    end
    rfull  = (rq.size() == DEPTH);
    rempty = (rq.size() == roff);
    mr_vld = 0;
    if (wren && rfull) mr_ovf = 1;
    if (rden && rempty && !rd_rewind) mr_unf = 1;
    if (rden && !rempty && !rd_rewind) begin
      mr_dat = rq[roff]; mr_vld = 1; roff++;
    end
    if (rd_rewind) roff = 0;
    else if (rd_mark) begin
      repeat (roff) void'(rq.pop_front());
      roff = 0;
    end
    if (wren && !rfull) rq.push_back(wrdata);

    pfull  = (pq.size() == DEPTH);
    pempty = (pq.size() == 0);
    mp_vld = 0;
    if (wren && pfull) mp_ovf = 1;
    if (rden && pempty) mp_unf = 1;
    if (rden && !pempty) begin
      mp_dat = pq.pop_front(); mp_vld = 1;
    end
    if (wren && !pfull) pq.push_back(wrdata);
  endtask

  task automatic check_all();
    int rs, rl, ps;
    rs = rq.size(); rl = rq.size() - roff; ps = pq.size();
    chk("r_vld",   32'(r_vld), 32'(mr_vld));
    chk("r_data",  32'(r_rddata), 32'(mr_dat));
    chk("r_rdlvl", 32'(r_rdl), 32'(rl));
    chk("r_wrlvl", 32'(r_wrl), 32'(rs));
    chk("r_flags", 32'({r_full, r_afull, r_empty, r_aempty, r_ovf, r_unf}),
        32'({rs == DEPTH, rs >= int'(af_level), rl == 0, rl <= int'(ae_level), mr_ovf, mr_unf}));
    chk("p_vld",   32'(p_vld), 32'(mp_vld));
    chk("p_data",  32'(p_rddata), 32'(mp_dat));
    chk("p_levels", 32'({p_rdl, p_wrl}), 32'({4'(ps), 4'(ps)}));
    chk("p_flags", 32'({p_full, p_afull, p_empty, p_aempty, p_ovf, p_unf}),
        32'({ps == DEPTH, ps >= int'(af_level), ps == 0, ps <= int'(ae_level), mp_ovf, mp_unf}));
  endtask

  task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r,
                      input bit m, input bit rw);
    wren = w; wrdata = d; rden = r; rd_mark = m; rd_rewind = rw;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_flush();
    wren = 0; rden = 0; rd_mark = 0; rd_rewind = 0; flush = 1;
    model_step();
    @(posedge clk);
    #1;
    flush = 0;
    check_all();
  endtask

  initial begin
    int nwr;
    // reset state, including almost_full when threshold is zero
    #1;
    model_reset();
    check_all();
    af_level = 4'd0;
    #1;
    chk("reset_af0", 32'(r_afull), 32'd1);
    af_level = 4'd6;
    @(negedge clk);
    reset_n = 1'b1;

    // fill to full, then a refused write
    for (int i = 1; i <= 8; i++) step(1, 16'(i), 0, 0, 0);
    chk("t1_full", 32'(r_full), 32'd1);
    chk("t1_wrlvl", 32'(r_wrl), 32'd8);
    step(1, 16'h0099, 0, 0, 0);
    chk("t1_ovf", 32'(r_ovf), 32'd1);

    // drain in order, then underflow
    for (int i = 1; i <= 8; i++) begin
      step(0, '0, 1, 0, 0);
      chk("t2_data", 32'(r_rddata), 32'(i));
    end
    chk("t2_empty", 32'(r_empty), 32'd1);
    step(0, '0, 1, 0, 0);
    chk("t2_unf", 32'(r_unf), 32'd1);
    chk("t2_novld", 32'(r_vld), 32'd0);

    // rewind to mark at 0 and replay
    step(0, '0, 0, 0, 1);
    chk("t3_rdlvl", 32'(r_rdl), 32'd8);
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 1);
    chk("t3_rewind", 32'(r_rdl), 32'd8);
    chk("t3_full", 32'(r_full), 32'd1);
    step(0, '0, 1, 0, 0);
    chk("t3_replay", 32'(r_rddata), 32'h0001);

    // mark while reading the third entry
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 1, 0);
    chk("t4_data3", 32'(r_rddata), 32'h0003);
    chk("t4_wrlvl", 32'(r_wrl), 32'd5);
    chk("t4_full", 32'(r_full), 32'd0);
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 0);
    chk("t4_data4", 32'(r_rddata), 32'h0004);

    // plain instance: 20 interleaved writes/reads through wraparound
    do_flush();
    nwr = 0;
    for (int i = 0; i < 60 && (nwr < 20 || pq.size() > 0); i++) begin
      bit w, r;
      w = (nwr < 20) && (pq.size() < DEPTH) && ($urandom_range(0, 2) != 0);
      r = (pq.size() > 0) && ($urandom_range(0, 1) != 0);
      step(w, 16'(16'h0100 + nwr), r, 0, 0);
      if (w) nwr++;
    end
    chk("t5_nerr", 32'({p_ovf, p_unf}), 32'd0);
    chk("t5_empty", 32'(p_empty), 32'd1);

    // thresholds and asynchronous reset mid-burst
    do_flush();
    for (int i = 0; i < 6; i++) step(1, 16'(16'h0200 + i), 0, 0, 0);
    chk("t6_afull", 32'(r_afull), 32'd1);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0);
    chk("t6_aempty", 32'(r_aempty), 32'd1);
    step(1, 16'h0300, 1, 0, 0);
    wren = 1; rden = 1; wrdata = 16'h0301;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_rst_empty", 32'(r_empty), 32'd1);
    wren = 0; rden = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic on all controls and thresholds
    for (int i = 0; i < 300; i++) begin
      af_level = 4'($urandom_range(0, 8));
      ae_level = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 49) == 0) do_flush();
      else step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
